// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
// Single clock domain; baud_tick is a one-cycle enable at OVERSAMPLE x the bit rate.
// Frames are LSB first: start bit, DATA_BITS data bits, optional parity, then
// STOP_BITS stop bits. The received word is presented on a valid/ready interface.
// Optional feature macro: UART_RX_PARITY_EN inserts the parity bit and its check.
// Without it, parity_err is tied low and PARITY_ODD has no effect.

module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,   // 5..9
    parameter int unsigned OVERSAMPLE = 16,  // even, >= 4
    parameter int unsigned STOP_BITS  = 1,   // 1 or 2
    parameter int unsigned PARITY_ODD = 0    // 0 = even, 1 = odd
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [2:0]           state
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    // Tick values where the start bit is checked (mid-bit) and where every later
    // bit is sampled (one full bit period after the previous sample point).
    localparam logic [TICK_W-1:0] TickMid  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TickLast = TICK_W'(OVERSAMPLE - 1);

    localparam logic [BIT_W-1:0] BitLastData = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BitLastStop = BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    // Synchronizer
    logic rx_meta_q;
    logic rxs_q;

    // Frame FSM and counters
    logic [2:0]           state_q,    state_d;
    logic [TICK_W-1:0]    tick_q,     tick_d;
    logic [BIT_W-1:0]     bit_q,      bit_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 armed_q,    armed_d;
    logic                 done;

    // Output holding registers
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    logic                 frame_par_err;

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    localparam logic ParOdd = (PARITY_ODD != 0);

    // Even sense expects the parity bit to equal the XOR of the data bits.
    assign frame_par_err = par_bit_q != ((^shreg_q) ^ ParOdd);
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign frame_par_err     = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Next-state logic: every counter and state change is gated by baud_tick.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        ferr_acc_d = ferr_acc_q;
        // A high line re-arms start detection (needed after a break).
        armed_d    = armed_q | rxs_q;
        done       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif

        if (baud_tick) begin
            case (state_q)
                StIdle: begin
                    if (armed_q && !rxs_q) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end

                StStart: begin
                    if (tick_q == TickMid) begin
                        tick_d = '0;
                        bit_d  = '0;
                        if (rxs_q) begin
                            // Line went back high before mid-bit: a glitch, not a start.
                            state_d = StIdle;
                        end else begin
                            state_d    = StData;
                            ferr_acc_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                StData: begin
                    if (tick_q == TickLast) begin
                        tick_d  = '0;
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == BitLastData) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                StParity: begin
`ifdef UART_RX_PARITY_EN
                    if (tick_q == TickLast) begin
                        par_bit_d = rxs_q;
                        tick_d    = '0;
                        bit_d     = '0;
                        state_d   = StStop;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
`else
                    // Unreachable without the parity option; recover to idle.
                    state_d = StIdle;
                    tick_d  = '0;
                    bit_d   = '0;
`endif
                end

                StStop: begin
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        if (!rxs_q) begin
                            ferr_acc_d = 1'b1;
                        end
                        if (bit_q == BitLastStop) begin
                            bit_d   = '0;
                            state_d = StIdle;
                            done    = 1'b1;
                            // A low stop bit may be a break: wait for the line to go high.
                            if (ferr_acc_q || !rxs_q) begin
                                armed_d = 1'b0;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // FSM, counter and shift register state; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            ferr_acc_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            ferr_acc_q <= ferr_acc_d;
            armed_q    <= armed_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit, compared against the data once the frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_q <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
        end
    end
`endif

    // Output holding register with valid/ready handshake and overrun detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (done) begin
            // A completing frame always wins; overrun only if the old one was not taken.
            rx_data_q    <= shreg_q;
            rx_valid_q   <= 1'b1;
            frame_err_q  <= ferr_acc_d;
            parity_err_q <= frame_par_err;
            overrun_q    <= rx_valid_q && !rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            // rx_data is deliberately left holding the consumed word.
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);
    assign state      = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param (default parameters).
// Frames are built bit by bit from the data value; expected results come from
// the frame contents and the handshake rules, compared against words the
// monitor collects at each accepted handshake.

module tb_uart_rx_param;

    localparam int DW      = 8;
    localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          baud_tick = 1'b0;
    logic          rx        = 1'b1;
    logic          rx_ready  = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;

    logic [1:0] tdiv = 2'd0;

    // Accepted words: {overrun, parity_err, frame_err, rx_data}
    logic [10:0] obs_q[$];
    int          vlen       = 0;
    int          last_vlen  = 0;
    int          start_cnt  = 0;
    logic [2:0]  prev_state = 3'd0;
    logic        pflip_cur  = 1'b0;

    uart_rx_param #(
        .DATA_BITS (DW),
        .OVERSAMPLE(16),
        .STOP_BITS (1),
        .PARITY_ODD(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv      <= tdiv + 2'd1;
        baud_tick <= (tdiv == 2'd3);
    end

    // Monitor on the falling edge: handshakes, valid pulse length, START entries.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            obs_q.push_back({overrun, parity_err, frame_err, rx_data});
        end
        if (rx_valid) begin
            vlen++;
        end else if (vlen != 0) begin
            last_vlen = vlen;
            vlen      = 0;
        end
        if (state == 3'd1 && prev_state == 3'd0) begin
            start_cnt++;
        end
        prev_state = state;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_v);
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < DW; i++) begin
            drive(d[i], BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ pflip_cur, BIT_CLK);
`endif
        drive(stop_v, BIT_CLK);
    endtask

    task automatic expect_frame(input string tag, input logic [DW-1:0] d, input logic fe,
                                input logic pe, input logic ov);
        logic [10:0] o;
        check({tag, "_count"}, obs_q.size(), 1);
        if (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            check({tag, "_data"}, o[7:0], d);
            check({tag, "_ferr"}, o[8], fe);
            check({tag, "_perr"}, o[9], pe);
            check({tag, "_ovr"}, o[10], ov);
        end
        obs_q.delete();
    endtask

    task automatic frame_ok(input string tag, input logic [DW-1:0] d);
        pflip_cur = 1'b0;
        send_frame(d, 1'b1);
        drive(1'b1, BIT_CLK);
        expect_frame(tag, d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          bad;
        int            s0;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        rst = 1'b0;
        drive(1'b1, 8);

        // 1. Clean frame, one-cycle valid pulse
        frame_ok("a5", 8'hA5);
        check("a5_vlen", last_vlen, 1);
        check("a5_state", state, 0);

        // 2. Start glitch rejected, then a clean frame
        s0 = start_cnt;
        drive(1'b0, 20);
        drive(1'b1, 2 * BIT_CLK);
        check("glitch_start", start_cnt - s0, 1);
        check("glitch_novalid", obs_q.size(), 0);
        check("glitch_state", state, 0);
        frame_ok("3c", 8'h3C);

        // 3. Framing error with break; no restart until the line goes high
        pflip_cur = 1'b0;
        s0 = start_cnt;
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 2 * BIT_CLK);
        expect_frame("brk", 8'h3C, 1'b1, 1'b0, 1'b0);
        check("brk_starts", start_cnt - s0, 1);
        check("brk_state", state, 0);
        drive(1'b1, BIT_CLK);
        frame_ok("81", 8'h81);

        // 4. Overrun with rx_ready low, then consume
        rx_ready = 1'b0;
        pflip_cur = 1'b0;
        send_frame(8'h11, 1'b1);
        drive(1'b1, BIT_CLK);
        check("ovr1_valid", rx_valid, 1);
        check("ovr1_data", rx_data, 8'h11);
        check("ovr1_ovr", overrun, 0);
        send_frame(8'h22, 1'b1);
        drive(1'b1, BIT_CLK);
        check("ovr2_valid", rx_valid, 1);
        check("ovr2_data", rx_data, 8'h22);
        check("ovr2_ovr", overrun, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_clr_valid", rx_valid, 0);
        check("ovr_clr_ovr", overrun, 0);
        check("ovr_hold_data", rx_data, 8'h22);
        expect_frame("ovr", 8'h22, 1'b0, 1'b0, 1'b1);

`ifdef UART_RX_PARITY_EN
        // 5. Parity check, even sense
        pflip_cur = 1'b1;
        send_frame(8'h07, 1'b1);
        drive(1'b1, BIT_CLK);
        expect_frame("par_bad", 8'h07, 1'b0, 1'b1, 1'b0);
        pflip_cur = 1'b0;
        send_frame(8'h07, 1'b1);
        drive(1'b1, BIT_CLK);
        expect_frame("par_ok", 8'h07, 1'b0, 1'b0, 1'b0);
`endif

        // 6. Reset in the middle of data bit 4
        d = 8'($urandom) | 8'h10;
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            drive(d[i], BIT_CLK);
        end
        drive(d[4], 32);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_flags", {frame_err, parity_err, overrun}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", state, 0);
        drive(1'b1, 12 * BIT_CLK);
        check("mid_rst_nopartial", obs_q.size(), 0);
        frame_ok("5a", 8'h5A);

        // Randomised frames: data, stop-bit errors, parity flips, tick phase, gaps
        for (int n = 0; n < 16; n++) begin
            d         = 8'($urandom_range(0, 255));
            bad       = ($urandom_range(0, 4) == 0);
            pflip_cur = 1'($urandom_range(0, 1));
            drive(1'b1, $urandom_range(0, 7));
            send_frame(d, !bad);
            drive(1'b1, $urandom_range(1, 3) * BIT_CLK);
            expect_frame("rand", d, bad, PAR_EN & pflip_cur, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It runs on a single system clock, with the oversampled baud rate delivered as a one-cycle enable instead of a second clock. It adds configurable data width, oversample rate and stop-bit count, start-glitch rejection, framing and overrun detection, and a valid/ready output handshake. It sits between the pad-side rx line and the byte-consumer logic (FIFO or command parser).

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; received LSB first.
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and >= 4.
STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
baud_tick  in  1  one-clk enable, OVERSAMPLE pulses per bit period.
rx  in  1  asynchronous serial line, idle high.
rx_ready  in  1  consumer accepts the frame when rx_valid and rx_ready are both 1.
rx_data  out  DATA_BITS  received data word.
rx_valid  out  1  frame held and available.
frame_err  out  1  a stop bit was sampled low; qualifies rx_data.
parity_err  out  1  parity mismatch; qualifies rx_data.
overrun  out  1  an unconsumed frame was overwritten.
busy  out  1  high in every state except IDLE.
state  out  3  current FSM state, for debug.

Behaviour:
- rx passes through a 2-FF synchronizer; both FFs reset to 1. All sampling uses the synchronized value (rxs).
- Tick counter is $clog2(OVERSAMPLE) bits wide. Bit counter is $clog2(DATA_BITS+1) bits wide. Both counters advance only on cycles where baud_tick=1.
- FSM state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE: armed only after rxs=1 has been seen; arming is immediate after reset. On a baud_tick with rxs=0 while armed -> START, tick=0.
- START: at tick==OVERSAMPLE/2-1 (mid-bit):
  - rxs=0 -> DATA, tick=0, bit=0.
  - rxs=1 -> IDLE (glitch rejected, nothing reported).
- DATA: at tick==OVERSAMPLE-1, shift rxs into the shift register MSB-side so bit 0 is the first bit received; bit++, tick=0. After the DATA_BITS-th sample -> PARITY if the macro is defined, else STOP.
- PARITY: one bit period, sampled at the same tick point.
- STOP: STOP_BITS bit periods. Any stop sample of 0 sets the frame error for that frame. After the last stop sample -> IDLE.
- Re-arm after a framing error (break condition): IDLE stays disarmed until rxs=1 is sampled.
- Completion: one clk after the baud_tick that samples the last stop bit:
  - rx_data, frame_err and parity_err are loaded and rx_valid=1.
- Handshake:
  - rx_valid stays high until rx_valid&rx_ready; it clears on the following clk edge together with frame_err, parity_err and overrun.
  - rx_data holds its value after clearing.
- Overrun: completion while rx_valid=1 and rx_ready=0 -> new frame overwrites rx_data and flags, rx_valid stays 1, overrun=1.
- Completion in the same cycle as a handshake: the new frame loads, rx_valid stays 1, overrun=0.
- Latency from the rx edge to the sampler: 2 clk of synchronizer delay plus up to one baud_tick period.
- Reset values, in every state including mid-frame:
  - rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, state=IDLE.
  - Counters=0, shift register=0, synchronizer FFs=1.
  - Any partial frame is discarded.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the PARITY state is inserted after DATA. The expected parity bit is ^data for even (PARITY_ODD=0) or ~^data for odd (PARITY_ODD=1). parity_err=1 on mismatch, reported with the frame.
- Undefined: the PARITY state is never entered, parity_err is tied to 0, and PARITY_ODD is ignored.

Test Plan:
All scenarios use OVERSAMPLE=16, baud_tick every 4 clk, DATA_BITS=8, STOP_BITS=1, rx_ready=1 unless stated.
1. Frame 0xA5 -> rx_valid high exactly 1 clk, rx_data=8'hA5, frame_err=parity_err=overrun=0, state returns to 0.
2. rx low for 5 ticks, then high -> state goes 1 then 0; rx_valid never asserts; a following 0x3C frame is received correctly.
3. Frame 0x3C with stop bit 0, rx held low 2 more bit times -> rx_valid with frame_err=1, rx_data=8'h3C; no new start accepted until rx returns high; then 0x81 is received cleanly.
4. rx_ready=0, frames 0x11 then 0x22 -> after the second frame rx_data=8'h22, overrun=1, rx_valid=1; raise rx_ready -> rx_valid and overrun are 0 on the next clk.
5. Macro defined, PARITY_ODD=0, data 0x07 sent with parity bit 0 -> parity_err=1; resent with parity bit 1 -> parity_err=0.
6. rst pulsed 1 clk during DATA bit 4 -> all outputs are 0 and state=0 on the next clk; the following frame 0x5A gives rx_data=8'h5A with no errors.
